pps_phase_stream: RTL
=====================

// Module: pps_phase_stream
// PURPOSE
//  N-channel PPS phase monitor. Measures each channel's rising edge relative to a reference
//  PPS in i_clk cycles. Each closed epoch becomes a snapshot, streamed out as NCH beats over
//  a valid/ready interface toward the UART answer path. Generalises the fixed 5-channel meter:
//  channel count, widths, timeout, dup/missing flags and overrun accounting are new.
// PARAMETERS
//  NCH          5            number of measured PPS channels (1..16)
//  CNT_W        30           phase counter width; must hold TIMEOUT
//  TIMEOUT      110000000    cycles without ref edge before the epoch is force-closed
//  SYNC_STAGES  2            input synchroniser depth (>=2), same for ref and channels
//  CH_W         clog2(NCH), min 1   channel index width (derived localparam)
// PORTS
//  i_clk          in   1       measurement clock, sole clock
//  i_res_n        in   1       asynchronous active-low reset
//  i_ref_pps      in   1       reference PPS, asynchronous
//  i_pps          in   NCH     measured PPS inputs, asynchronous
//  o_valid        out  1       beat valid
//  i_ready        in   1       sink ready
//  o_ch           out  CH_W    channel index of beat
//  o_phase        out  CNT_W   cycles from ref edge to channel edge; all-ones if absent
//  o_present      out  1       channel edge seen in epoch
//  o_dup          out  1       >1 channel edge seen in epoch
//  o_ref_lost     out  1       epoch closed by TIMEOUT, not a ref edge
//  o_last         out  1       final beat of snapshot (o_ch==NCH-1)
//  o_busy         out  1       snapshot streaming in progress
//  o_overrun_cnt  out  8       snapshots dropped while busy, saturating at 255
// BEHAVIOUR
//  Reset: all outputs 0. Counter 0, armed=0, FSM IDLE, per-channel flags cleared.
//  Inputs pass through SYNC_STAGES flops, then rising-edge detect (sync_q & ~sync_q_d).
//   Equal pipeline on all inputs; the fixed offset cancels in the phase.
//  Counter: increments every cycle; loads 0 on ref edge or on reaching TIMEOUT-1 (wrap).
//  Channel edge while counter = C: first edge in epoch latches phase=C, present=1.
//   Later edges only set dup=1.
//  Epoch close: ref edge, or counter==TIMEOUT-1 with no ref edge that cycle.
//   Ref edge sets armed=1. Close when armed=0 publishes nothing.
//   TIMEOUT close sets snapshot ref_lost=1. A timeout close does not clear armed.
//  Simultaneous ref edge and channel edge in the same cycle: the channel edge belongs to
//   the NEW epoch, phase 0. The closing snapshot excludes it.
//  On close, working regs copy to the snapshot buffer and clear in the same cycle, unless
//   FSM is STREAM: then the snapshot is dropped and o_overrun_cnt increments (sat 255).
//   Working regs clear either way.
//  FSM IDLE: if snapshot pending -> STREAM next cycle, beat idx 0.
//   Output latency is 1 cycle after close.
//  FSM STREAM: o_valid=1, o_busy=1. Beat fields are driven from the buffer at idx.
//   Absent channel: o_phase all-ones, o_present=0, o_dup=0. o_ref_lost is the same on every beat.
//   Beat accepted on o_valid&i_ready -> idx+1. When idx==NCH-1 is accepted -> IDLE, o_valid=0.
//  Beat fields stay stable while o_valid&~i_ready. o_valid never drops before acceptance.
//  Snapshot closing in the same cycle the last beat is accepted: stored, not overrun.
//   FSM returns to STREAM the following cycle.
//  Async reset mid-stream: beats abandoned, o_valid=0 immediately, overrun count cleared.
// TESTING (NCH=4, CNT_W=12, TIMEOUT=1000, SYNC_STAGES=2)
//  ref edges 500 cycles apart; ch0 +10, ch1 +200, ch3 0, ch2 silent; i_ready=1 ->
//   4 beats: phase 10,200,4095,0. present 1,1,0,1. o_last on ch3. ref_lost=0.
//  First ref edge after reset, no prior epoch -> no output. Second ref edge -> 1 snapshot.
//  Ref stops after armed -> snapshot at counter 999 with ref_lost=1. Repeats every 1000
//   cycles.
//  ch1 pulses twice in one epoch (+50,+300) -> phase 50, dup=1.
//  i_ready=0 for 1200 cycles across 2 closes -> fields held stable, o_overrun_cnt=2.
//   On release, original snapshot completes.
//  ch0 edge in same cycle as ref edge -> reported phase 0 in next epoch, absent in closing one.
//  Assert i_res_n=0 during beat 2 -> o_valid=0 at once. After release, armed=0, no output
//   until 2 ref edges.

Source files
------------

// File: rtl/pps_phase_stream.sv
// N-channel PPS phase meter: per-epoch phase of each channel edge relative to the reference PPS.
// Latency: a snapshot's first beat is valid 1 cycle after its epoch closes (plus the input synchroniser).
// Backpressure: beats hold while o_valid & ~i_ready; epochs closing while streaming are dropped and counted.
module pps_phase_stream #(
  parameter int NCH         = 5,
  parameter int CNT_W       = 30,
  parameter int TIMEOUT     = 110000000,
  parameter int SYNC_STAGES = 2,
  localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             i_clk,
  input  logic             i_res_n,
  input  logic             i_ref_pps,
  input  logic [NCH-1:0]   i_pps,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [CH_W-1:0]  o_ch,
  output logic [CNT_W-1:0] o_phase,
  output logic             o_present,
  output logic             o_dup,
  output logic             o_ref_lost,
  output logic             o_last,
  output logic             o_busy,
  output logic [7:0]       o_overrun_cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CH_W-1:0]  IDX_LAST = CH_W'(NCH - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t state, state_nxt;

  // Synchroniser chains and edge-detect history
  logic [SYNC_STAGES-1:0] ref_sync;
  logic [NCH-1:0]         pps_sync [SYNC_STAGES];
  logic                   ref_q_d;
  logic [NCH-1:0]         pps_q_d;
  logic                   ref_edge;
  logic [NCH-1:0]         pps_edge;

  // Epoch timing
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_cur;
  logic             wrap;
  logic             close;
  logic             armed;

  // Working (open epoch) registers and their value including this cycle's edges
  logic [CNT_W-1:0] w_phase [NCH];
  logic [NCH-1:0]   w_present;
  logic [NCH-1:0]   w_dup;
  logic [CNT_W-1:0] m_phase [NCH];
  logic [NCH-1:0]   m_present;
  logic [NCH-1:0]   m_dup;

  // Snapshot buffer being streamed
  logic [CNT_W-1:0] s_phase [NCH];
  logic [NCH-1:0]   s_present;
  logic [NCH-1:0]   s_dup;
  logic             s_lost;

  logic [CH_W-1:0]  idx;
  logic [7:0]       overrun;
  logic             beat_acc;
  logic             last_acc;
  logic             publish;
  logic             drop;

  // Bring the asynchronous PPS inputs into i_clk through identical pipelines
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      ref_sync <= '0;
      for (int k = 0; k < SYNC_STAGES; k++) pps_sync[k] <= '0;
      ref_q_d  <= 1'b0;
      pps_q_d  <= '0;
    end else begin
      ref_sync    <= {ref_sync[SYNC_STAGES-2:0], i_ref_pps};
      pps_sync[0] <= i_pps;
      for (int k = 1; k < SYNC_STAGES; k++) pps_sync[k] <= pps_sync[k-1];
      ref_q_d     <= ref_sync[SYNC_STAGES-1];
      pps_q_d     <= pps_sync[SYNC_STAGES-1];
    end
  end

  assign ref_edge = ref_sync[SYNC_STAGES-1] & ~ref_q_d;
  assign pps_edge = pps_sync[SYNC_STAGES-1] & ~pps_q_d;

  // The ref-edge cycle itself counts as phase 0, so an edge k cycles later reads k
  assign cnt_cur  = ref_edge ? '0 : cnt;
  assign wrap     = ~ref_edge & (cnt == CNT_LAST);
  assign close    = ref_edge | wrap;

  assign beat_acc = (state == STREAM) & i_ready;
  assign last_acc = beat_acc & (idx == IDX_LAST);
  // A snapshot may land in the buffer only when the previous one is fully consumed
  assign publish  = close & armed & ((state != STREAM) | last_acc);
  assign drop     = close & armed & (state == STREAM) & ~last_acc;

  // Fold this cycle's channel edges into the open epoch; a ref-coincident edge is excluded
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      m_phase[c]   = (pps_edge[c] & ~ref_edge & ~w_present[c]) ? cnt : w_phase[c];
      m_present[c] = w_present[c] | (pps_edge[c] & ~ref_edge);
      m_dup[c]     = w_dup[c] | (pps_edge[c] & ~ref_edge & w_present[c]);
    end
  end

  // Phase counter and arming on the first reference edge
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt_cur + CNT_W'(1);
      if (ref_edge) armed <= 1'b1;
    end
  end

  // Working registers: accumulate within an epoch, restart on close (seeding a ref-coincident edge at 0)
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      for (int c = 0; c < NCH; c++) w_phase[c] <= '0;
      w_present <= '0;
      w_dup     <= '0;
    end else if (close) begin
      for (int c = 0; c < NCH; c++) w_phase[c] <= '0;
      w_present <= pps_edge & {NCH{ref_edge}};
      w_dup     <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) w_phase[c] <= m_phase[c];
      w_present <= m_present;
      w_dup     <= m_dup;
    end
  end

  // Snapshot buffer capture and saturating drop counter
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      for (int c = 0; c < NCH; c++) s_phase[c] <= '0;
      s_present <= '0;
      s_dup     <= '0;
      s_lost    <= 1'b0;
      overrun   <= '0;
    end else begin
      if (publish) begin
        for (int c = 0; c < NCH; c++) s_phase[c] <= m_phase[c];
        s_present <= m_present;
        s_dup     <= m_dup;
        s_lost    <= ~ref_edge;
      end
      if (drop && overrun != 8'hFF) overrun <= overrun + 8'd1;
    end
  end

  // Beat index advances on each accepted beat and rewinds after the last one
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      idx <= '0;
    end else if (beat_acc) begin
      idx <= last_acc ? '0 : idx + CH_W'(1);
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next state: stream a fresh snapshot, chaining directly if one closes on the last beat
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (publish) state_nxt = STREAM;
      STREAM:  if (last_acc) state_nxt = publish ? STREAM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: beat fields come from the buffer and are zero whenever no beat is offered
  always_comb begin
    o_valid       = (state == STREAM);
    o_busy        = (state == STREAM);
    o_ch          = '0;
    o_phase       = '0;
    o_present     = 1'b0;
    o_dup         = 1'b0;
    o_ref_lost    = 1'b0;
    o_last        = 1'b0;
    o_overrun_cnt = overrun;
    if (state == STREAM) begin
      o_ch       = idx;
      o_phase    = s_present[idx] ? s_phase[idx] : '1;
      o_present  = s_present[idx];
      o_dup      = s_present[idx] & s_dup[idx];
      o_ref_lost = s_lost;
      o_last     = (idx == IDX_LAST);
    end
  end

endmodule
